sevenseg_scan_ctrl: RTL and testbench
=====================================

SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is driven; legal range >=1.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: dead-time cycles with all anodes off between digits; legal range >=0.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_load_valid, input, 1 bit: a new 4-digit value is offered.
REQ-006 SHALL have port in_load_data, input, 16 bits: digit d is bits [4d+3:4d]; digit 0 is rightmost.
REQ-007 SHALL have port out_load_ready, output, 1 bit: the shadow register can accept a value.
REQ-008 SHALL have port in_blank_mask, input, 4 bits: bit d=1 keeps digit d dark during its slot.
REQ-009 SHALL have port out_nibble, output, 4 bits: BCD/hex nibble for the external sevenseg decoder, MSB to its in_a.
REQ-010 SHALL have port out_digit_sel, output, 4 bits: one-hot active-low anode enables.
REQ-011 SHALL have port out_frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL have states IDLE, DRIVE and GAP, plus a 2-bit digit index, a SCAN_DIV cycle counter, a GAP_CYCLES counter, a 16-bit display register, a 16-bit shadow register and a pending flag.
REQ-013 SHALL accept a load when in_load_valid and out_load_ready are both high in the same cycle: in_load_data goes into the shadow register and pending is set.
REQ-014 SHALL drive out_load_ready as the inverse of pending; while pending is set, in_load_valid is ignored.
REQ-015 SHALL, in IDLE, keep out_digit_sel=4'b1111; on the cycle after pending is set, commit shadow to display, clear pending, set index 0 and enter DRIVE.
REQ-016 SHALL, in DRIVE, drive out_nibble with display[4d+3:4d] and pull out_digit_sel[d] low (unless it is blanked) for exactly SCAN_DIV cycles, then enter GAP.
REQ-017 SHALL, in GAP, hold out_digit_sel=4'b1111 and out_nibble unchanged for GAP_CYCLES cycles, then set index d+1 mod 4 and enter DRIVE; when GAP_CYCLES=0, DRIVE goes straight to the next DRIVE.
REQ-018 SHALL treat the last cycle of digit 3's slot (its gap if GAP_CYCLES>0, otherwise its drive) as the frame boundary: assert out_frame_tick, and if pending is set, commit shadow to display and clear pending, so the new value appears starting at digit 0.
REQ-019 SHALL, when commit and in_load_valid coincide, leave the new offer unaccepted that cycle (ready is low); it is accepted on the next cycle.
REQ-020 SHALL sample in_blank_mask combinationally every cycle; blanking never changes slot timing.
REQ-021 SHALL make the frame period exactly 4*(SCAN_DIV+GAP_CYCLES) cycles; the counters are sized for the parameters with no wrap error.

Reset
REQ-022 SHALL, while rst_n is low, immediately force: state IDLE, out_digit_sel=4'b1111, out_nibble=0, out_frame_tick=0, out_load_ready=1, display=0, shadow=0, pending=0, index and counters=0.
REQ-023 SHALL, when reset is asserted mid-frame, abort the frame, turn all anodes off asynchronously and discard any pending value.

Configuration
REQ-024 SHALL compile leading-zero suppression in when SEVENSEG_LEADING_ZERO_BLANK_EN is defined: digit d (d=3..1) stays dark whenever display nibble d and all nibbles above it are zero; digit 0 is never suppressed; this ORs with in_blank_mask.
REQ-025 SHALL, when SEVENSEG_LEADING_ZERO_BLANK_EN is undefined, show all digits, including zeros, subject only to in_blank_mask.

Verification (SCAN_DIV=4, GAP_CYCLES=2, frame 24 cycles)
REQ-026 SHALL check reset behaviour: after reset, with no load for 50 cycles -> out_digit_sel=1111, out_load_ready=1, out_frame_tick never pulses.
REQ-027 SHALL check load and scan: load 16'h1234 -> next cycle DRIVE digit 0: out_nibble=4, sel=1110 for 4 cycles, then 1111 for 2 cycles, then nibble=3 and sel=1101, and so on; tick every 24 cycles.
REQ-028 SHALL check shadow commit at the boundary: mid-frame load 16'hABCD while 16'h1234 is displayed -> ready drops the next cycle; digits 2 and 3 still show 2 and 1; tick cycle commits; next digit 0 shows D; ready returns high.
REQ-029 SHALL check blanking: in_blank_mask=0100 with 16'h1234 -> digit 2 slot keeps sel=1111 for 4 cycles; frame stays 24 cycles.
REQ-030 SHALL check the leading-zero option: with SEVENSEG_LEADING_ZERO_BLANK_EN and 16'h0050 -> digits 3 and 2 dark, digits 1 and 0 lit showing 5 and 0; 16'h0000 -> only digit 0 lit, showing 0.
REQ-031 SHALL check reset mid-operation: assert rst_n low during digit 1 DRIVE with pending set -> sel=1111 in the same cycle; after release, state IDLE and pending=0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with a shadow load register.
// Optional build macro SEVENSEG_LEADING_ZERO_BLANK_EN adds leading-zero suppression.
module sevenseg_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_load_valid,
  input  logic [15:0] in_load_data,
  output logic        out_load_ready,
  input  logic [3:0]  in_blank_mask,
  output logic [3:0]  out_nibble,
  output logic [3:0]  out_digit_sel,
  output logic        out_frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_gcnt;
  logic [15:0]   r_disp;
  logic [15:0]   r_shadow;
  logic          r_pend;

  logic       w_load;
  logic       w_drive_last;
  logic       w_gap_last;
  logic       w_tick;
  logic [3:0] w_lz;
  logic [3:0] w_blank;
  logic [3:0] w_onehot;

  assign w_load       = in_load_valid & ~r_pend;
  assign w_drive_last = (r_state == DRIVE) && (r_cnt == CNT_LAST);
  assign w_gap_last   = (r_state == GAP) && (r_gcnt == GAP_LAST);
  // Frame boundary is the final cycle of digit 3's slot, wherever that slot ends.
  assign w_tick       = (r_idx == 2'd3) && ((GAP_CYCLES > 0) ? w_gap_last : w_drive_last);

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  assign w_lz[3] = (r_disp[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'h0);
  assign w_lz[0] = 1'b0;
`else
  assign w_lz = 4'b0000;
`endif

  assign w_blank  = in_blank_mask | w_lz;
  assign w_onehot = 4'b0001 << r_idx;

  assign out_load_ready = ~r_pend;
  assign out_nibble     = r_disp[{r_idx, 2'b00} +: 4];
  assign out_digit_sel  = (r_state == DRIVE) ? ~(w_onehot & ~w_blank) : 4'b1111;
  assign out_frame_tick = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_gcnt   <= '0;
      r_disp   <= 16'h0000;
      r_shadow <= 16'h0000;
      r_pend   <= 1'b0;
    end else begin
      if (w_load) begin
        r_shadow <= in_load_data;
        r_pend   <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (r_pend) begin
            r_disp  <= r_shadow;
            r_pend  <= 1'b0;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          if (w_drive_last) begin
            r_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_gcnt  <= '0;
              r_state <= GAP;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        GAP: begin
          if (w_gap_last) begin
            r_gcnt  <= '0;
            r_idx   <= r_idx + 2'd1;
            r_state <= DRIVE;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
      // A held value swaps in only at the frame edge so digit 0 starts the new frame.
      if (w_tick && r_pend) begin
        r_disp <= r_shadow;
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with SCAN_DIV=4, GAP_CYCLES=2 (24-cycle frame).
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_load_valid;
  logic [15:0] in_load_data;
  logic        out_load_ready;
  logic [3:0]  in_blank_mask;
  logic [3:0]  out_nibble;
  logic [3:0]  out_digit_sel;
  logic        out_frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  sevenseg_scan_ctrl #(.SCAN_DIV(4), .GAP_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_load_valid  (in_load_valid),
    .in_load_data   (in_load_data),
    .out_load_ready (out_load_ready),
    .in_blank_mask  (in_blank_mask),
    .out_nibble     (out_nibble),
    .out_digit_sel  (out_digit_sel),
    .out_frame_tick (out_frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one full frame starting at its first cycle; optionally offers a load at cycle load_at.
  task automatic check_frame(input logic [15:0] val, input logic [3:0] mask,
                             input int load_at, input logic [15:0] load_val);
    logic [3:0] lz;
    logic [3:0] onehot;
    logic [3:0] exp_sel;
    logic [3:0] exp_nib;
    int d;
    int pos;
    in_blank_mask = mask;
    #1;
    lz = 4'b0000;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    for (int j = 1; j < 4; j++) lz[j] = ((val >> (4 * j)) == 16'h0000);
`endif
    for (int k = 0; k < 24; k++) begin
      d       = k / 6;
      pos     = k % 6;
      onehot  = 4'b0001 << d;
      exp_nib = val[4*d +: 4];
      exp_sel = (pos < 4 && !mask[d] && !lz[d]) ? ~onehot : 4'b1111;
      chk($sformatf("sel[%h k%0d]", val, k), {28'd0, out_digit_sel}, {28'd0, exp_sel});
      chk($sformatf("nib[%h k%0d]", val, k), {28'd0, out_nibble}, {28'd0, exp_nib});
      chk($sformatf("tick[%h k%0d]", val, k), {31'd0, out_frame_tick}, {31'd0, k == 23});
      if (k == 0) chk("ready_frame_start", {31'd0, out_load_ready}, 32'd1);
      if (load_at >= 0) begin
        if (k == load_at) begin
          in_load_valid = 1'b1;
          in_load_data  = load_val;
        end
        if (k == load_at + 1) begin
          chk("ready_after_load", {31'd0, out_load_ready}, 32'd0);
          in_load_data = ~load_val;
        end
        if (k == load_at + 2) in_load_valid = 1'b0;
        if (k == 23) chk("ready_pending_at_tick", {31'd0, out_load_ready}, 32'd0);
      end
      step();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_load_valid = 1'b0;
    in_load_data  = 16'h0000;
    in_blank_mask = 4'b0000;
    #2;
    chk("rst_sel", {28'd0, out_digit_sel}, 32'hF);
    chk("rst_ready", {31'd0, out_load_ready}, 32'd1);
    chk("rst_tick", {31'd0, out_frame_tick}, 32'd0);
    chk("rst_nib", {28'd0, out_nibble}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_sel", {28'd0, out_digit_sel}, 32'hF);
      chk("idle_ready", {31'd0, out_load_ready}, 32'd1);
      chk("idle_tick", {31'd0, out_frame_tick}, 32'd0);
    end

    in_load_valid = 1'b1;
    in_load_data  = 16'h1234;
    step();
    chk("first_load_ready", {31'd0, out_load_ready}, 32'd0);
    chk("first_load_sel", {28'd0, out_digit_sel}, 32'hF);
    in_load_valid = 1'b0;
    step();

    check_frame(16'h1234, 4'b0000, -1, 16'h0000);
    check_frame(16'h1234, 4'b0000, -1, 16'h0000);
    check_frame(16'h1234, 4'b0000, 8, 16'hABCD);
    check_frame(16'hABCD, 4'b0000, 2, 16'h1234);
    check_frame(16'h1234, 4'b0100, 2, 16'h0050);
    check_frame(16'h0050, 4'b0000, 2, 16'h0000);
    check_frame(16'h0000, 4'b0000, -1, 16'h0000);

    in_load_valid = 1'b1;
    in_load_data  = 16'h5678;
    step();
    in_load_valid = 1'b0;
    for (int i = 1; i < 7; i++) step();
    chk("pre_rst_sel_digit1", {28'd0, out_digit_sel}, 32'hD);
    chk("pre_rst_pending", {31'd0, out_load_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", {28'd0, out_digit_sel}, 32'hF);
    chk("midrst_ready", {31'd0, out_load_ready}, 32'd1);
    chk("midrst_nib", {28'd0, out_nibble}, 32'd0);
    chk("midrst_tick", {31'd0, out_frame_tick}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("post_rst_sel", {28'd0, out_digit_sel}, 32'hF);
      chk("post_rst_ready", {31'd0, out_load_ready}, 32'd1);
      chk("post_rst_tick", {31'd0, out_frame_tick}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
